// File: rtl/control_unit.sv
// Multi-cycle control unit: fetches a 16-bit word at pc, decodes it and sequences the datapath.
// Latency: ALU op 4 cycles, LDI 3 cycles, jump/NOP 2 cycles from one FETCH to the next.
// Backpressure: en=0 freezes every register and forces we3 low; the sequence resumes in the same state.
//
// Ports:
//   clk, reset (async, active-low), en        clocking / reset / global stall
//   instr[15:0]                                program word at address pc
//   zero, carry, sign                          ALU flags, captured in EXEC
//   pc[9:0]                                    program address register
//   ALUOp[1:0], arit, ra1, ra2, wa3, inm, s_inm decode fields, taken from the IR
//   we3                                        register-file write strobe (WB only)
//   fz, fc, fs, halted                         latched flags and halt indicator
module control_unit (
    input  logic        clk,
    input  logic        reset,
    input  logic        en,
    input  logic [15:0] instr,
    input  logic        zero,
    input  logic        carry,
    input  logic        sign,
    output logic [9:0]  pc,
    output logic [1:0]  ALUOp,
    output logic        arit,
    output logic [3:0]  ra1,
    output logic [3:0]  ra2,
    output logic [3:0]  wa3,
    output logic [3:0]  inm,
    output logic        s_inm,
    output logic        we3,
    output logic        fz,
    output logic        fc,
    output logic        fs,
    output logic        halted
);

    typedef enum logic [2:0] {
        FETCH  = 3'd0,
        DECODE = 3'd1,
        EXEC   = 3'd2,
        WB     = 3'd3,
        HALTED = 3'd4
    } state_t;

    localparam logic [2:0] OP_NOP  = 3'b000;
    localparam logic [2:0] OP_JMP  = 3'b001;
    localparam logic [2:0] OP_JZ   = 3'b010;
    localparam logic [2:0] OP_JNZ  = 3'b011;
    localparam logic [2:0] OP_JC   = 3'b100;
    localparam logic [2:0] OP_JS   = 3'b101;
    localparam logic [2:0] OP_LDI  = 3'b110;
    localparam logic [2:0] OP_HALT = 3'b111;

    state_t      state;
    logic [15:0] ir;
    logic        take_jump;
    logic [9:0]  pc_next_seq;

    // Decode fields come from the IR only, so they stay stable while instr
    // (addressed by pc) changes underneath once pc advances.
    assign ALUOp = ir[13:12];
    assign arit  = ir[14];
    assign ra1   = ir[7:4];
    assign ra2   = ir[3:0];
    assign wa3   = ir[11:8];
    assign inm   = ir[3:0];
    assign s_inm = (ir[15:12] == {1'b0, OP_LDI});

    // Decoded from the state register so an asynchronous reset drops the
    // strobe at once, and a stall in WB suppresses the write for that cycle.
    assign we3 = (state == WB) && en;

    // Natural 10-bit overflow gives the 1023 -> 0 wrap.
    assign pc_next_seq = pc + 10'd1;

    // Branch conditions look at the flags latched by the last ALU op,
    // never at the live ALU flag inputs.
    always_comb begin
        take_jump = 1'b0;
        case (ir[14:12])
            OP_JMP:  take_jump = 1'b1;
            OP_JZ:   take_jump = fz;
            OP_JNZ:  take_jump = ~fz;
            OP_JC:   take_jump = fc;
            OP_JS:   take_jump = fs;
            default: take_jump = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state  <= FETCH;
            pc     <= 10'd0;
            ir     <= 16'd0;
            fz     <= 1'b0;
            fc     <= 1'b0;
            fs     <= 1'b0;
            halted <= 1'b0;
        end else if (en) begin
            case (state)
                FETCH: begin
                    ir    <= instr;
                    state <= DECODE;
                end
                DECODE: begin
                    if (ir[15]) begin
                        state <= EXEC;
                    end else begin
                        case (ir[14:12])
                            OP_LDI: state <= WB;
                            OP_HALT: begin
                                halted <= 1'b1;
                                state  <= HALTED;
                            end
                            OP_JMP, OP_JZ, OP_JNZ, OP_JC, OP_JS: begin
                                pc    <= take_jump ? ir[9:0] : pc_next_seq;
                                state <= FETCH;
                            end
                            default: begin
                                // OP_NOP and anything unassigned in 0xxx
                                pc    <= pc_next_seq;
                                state <= FETCH;
                            end
                        endcase
                    end
                end
                EXEC: begin
                    fz    <= zero;
                    fc    <= carry;
                    fs    <= sign;
                    state <= WB;
                end
                WB: begin
                    pc    <= pc_next_seq;
                    state <= FETCH;
                end
                HALTED: state <= HALTED;
                default: state <= FETCH;
            endcase
        end
    end

endmodule
